// File: rtl/sobel_window_gen.sv
// sobel_window_gen
//   Turns a raster pixel stream into 3x3 neighbourhoods for the Sobel
//   gradient stage. Two line buffers hold the previous two rows. A 3x3
//   shift register holds the current window. One window is emitted per
//   accepted interior pixel, one clock after that pixel is accepted.
//
// Ports
//   clk        system clock
//   reset      asynchronous active-high reset
//   pix_in     pixel data (DW bits)
//   pix_valid  pixel strobe
//   hcount     column of pix_in (11 bits)
//   vcount     row of pix_in (11 bits)
//   sync_clr   synchronous frame restart; dominates pix_valid
//   win        3x3 window; tap (r,c) at win[(3*r+c)*DW +: DW]
//   win_valid  single-cycle strobe qualifying win/ctr_*/markers
//   ctr_h      column of the window centre
//   ctr_v      row of the window centre
//   win_first  window centre is (1,1)
//   win_last   window centre is (VMAX-2, HMAX-2)
module sobel_window_gen #(
    parameter int HMAX = 640,
    parameter int VMAX = 480,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   pix_in,
    input  logic            pix_valid,
    input  logic [10:0]     hcount,
    input  logic [10:0]     vcount,
    input  logic            sync_clr,
    output logic [9*DW-1:0] win,
    output logic            win_valid,
    output logic [10:0]     ctr_h,
    output logic [10:0]     ctr_v,
    output logic            win_first,
    output logic            win_last
);

    localparam int AW = (HMAX > 1) ? $clog2(HMAX) : 1;

    // lb0 holds row v-1 and lb1 holds row v-2. The RAM has no reset.
    logic [DW-1:0] lb0_mem [HMAX];
    logic [DW-1:0] lb1_mem [HMAX];

    logic [AW-1:0]   addr;
    logic [DW-1:0]   lb0_rd;
    logic [DW-1:0]   lb1_rd;
    logic            accept;
    logic            emit;

    logic [9*DW-1:0] taps_q, taps_d;
    logic [9*DW-1:0] win_q, win_d;
    logic            win_valid_q, win_valid_d;
    logic [10:0]     ctr_h_q, ctr_h_d;
    logic [10:0]     ctr_v_q, ctr_v_d;
    logic            win_first_q, win_first_d;
    logic            win_last_q, win_last_d;

    assign addr   = hcount[AW-1:0];
    assign accept = pix_valid && !sync_clr &&
                    (hcount < 11'(HMAX)) && (vcount < 11'(VMAX));
    // The h>=2 and v>=2 gates keep stale columns from the previous line
    // and stale rows from the previous frame out of every emitted window.
    assign emit   = accept && (vcount >= 11'd2) && (hcount >= 11'd2);

    always_comb begin
        // The read is combinational, so it sees the contents from before
        // this cycle's write to the same address.
        lb0_rd      = lb0_mem[addr];
        lb1_rd      = lb1_mem[addr];
        taps_d      = taps_q;
        win_d       = win_q;
        ctr_h_d     = ctr_h_q;
        ctr_v_d     = ctr_v_q;
        win_valid_d = 1'b0;
        win_first_d = 1'b0;
        win_last_d  = 1'b0;
        if (sync_clr) begin
            taps_d = '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                taps_d[(3*r)*DW   +: DW] = taps_q[(3*r+1)*DW +: DW];
                taps_d[(3*r+1)*DW +: DW] = taps_q[(3*r+2)*DW +: DW];
            end
            taps_d[2*DW +: DW] = lb1_rd;
            taps_d[5*DW +: DW] = lb0_rd;
            taps_d[8*DW +: DW] = pix_in;
            if (emit) begin
                win_d       = taps_d;
                ctr_h_d     = hcount - 11'd1;
                ctr_v_d     = vcount - 11'd1;
                win_valid_d = 1'b1;
                win_first_d = (vcount == 11'd2) && (hcount == 11'd2);
                win_last_d  = (vcount == 11'(VMAX - 1)) && (hcount == 11'(HMAX - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[addr] <= lb0_rd;
            lb0_mem[addr] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taps_q      <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            ctr_h_q     <= '0;
            ctr_v_q     <= '0;
            win_first_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            taps_q      <= taps_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            ctr_h_q     <= ctr_h_d;
            ctr_v_q     <= ctr_v_d;
            win_first_q <= win_first_d;
            win_last_q  <= win_last_d;
        end
    end

    assign win       = win_q;
    assign win_valid = win_valid_q;
    assign ctr_h     = ctr_h_q;
    assign ctr_v     = ctr_v_q;
    assign win_first = win_first_q;
    assign win_last  = win_last_q;

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Sits between the pixel source and the Sobel gradient stage, alongside frame_counter.
- Takes the raw pixel stream, tagged with the hcount/vcount that frame_counter holds for the pixel being presented.
- Keeps two line buffers and a 3x3 shift window.
- Emits one complete 3x3 neighbourhood per interior pixel, so the gradient stage is purely combinational or pipelined over the window.

Parameters:
HMAX, 640, pixels per line; line buffer depth
VMAX, 480, lines per frame
DW, 8, pixel data width in bits

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
pix_in  input  DW  incoming pixel data
pix_valid  input  1  pixel accepted this cycle (same strobe that drives frame_counter inc)
hcount  input  11  column of pix_in (frame_counter hcount, pre-increment)
vcount  input  11  row of pix_in (frame_counter vcount, pre-increment)
sync_clr  input  1  synchronous frame restart (same as frame_counter sync_clr)
win  output  9*DW  3x3 window; tap (r,c) at win[(3*r+c)*DW +: DW]; r=0 top row, c=0 left column
win_valid  output  1  win, ctr_h, ctr_v, win_first, win_last valid this cycle
ctr_h  output  11  column of window centre
ctr_v  output  11  row of window centre
win_first  output  1  window centre is (1,1)
win_last  output  1  window centre is (VMAX-2, HMAX-2)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: win=0, win_valid=0, ctr_h=0, ctr_v=0, win_first=0, win_last=0. Window column registers clear to 0. Line buffer RAM is not cleared.
- Accept condition: pix_valid=1 and sync_clr=0 and hcount<HMAX and vcount<VMAX. Any other cycle changes no state: no RAM write, no window shift, win_valid=0 next cycle.
- Line buffers: lb0 holds row v-1 and lb1 holds row v-2, each HMAX x DW, addressed by hcount.
  - On accept at (v,h), read old lb0[h] and lb1[h].
  - Then write lb1[h] <= old lb0[h] and lb0[h] <= pix_in.
  - The read must return pre-write data, i.e. read-before-write on the same address.
- Window shift: on accept, each row shifts left one column. The new right column is {top=lb1[h], mid=lb0[h], bottom=pix_in}.
- Emission:
  - On accept at (v,h) with v>=2 and h>=2, the next cycle has win_valid=1, ctr_v=v-1, ctr_h=h-1.
  - win holds rows v-2..v and columns h-2..h, including the pixel just accepted.
  - Latency is 1 clock from accept to win_valid.
  - win_valid is a single-cycle pulse per accept; no backpressure.
- Border rule: windows are emitted only for interior centres, rows 1..VMAX-2 and columns 1..HMAX-2. That is exactly (HMAX-2)*(VMAX-2) windows per complete frame.
  - Stale columns from the previous line are never emitted, because of the h>=2 gate.
  - Stale rows from the previous frame are never emitted, because of the v>=2 gate.
- Markers: win_first=1 only with the window for centre (1,1). win_last=1 only with the window for centre (VMAX-2,HMAX-2). Both are 0 whenever win_valid=0.
- Held outputs: win, ctr_h and ctr_v hold their last value while win_valid=0.
- Stalls: arbitrary gaps between accepts have no effect on the window contents or order.
- sync_clr:
  - Pixels presented in a sync_clr cycle are discarded and win_valid=0 next cycle.
  - Window column registers clear; RAM is untouched.
  - The next accepted pixel is expected at (0,0).
- Simultaneous events: reset dominates sync_clr, and sync_clr dominates pix_valid.
- Reset mid-frame: outputs clear at once. Correct windows resume only after the source restarts at (0,0) and rows 0 and 1 are refilled.
- Widths: hcount, vcount, ctr_h and ctr_v are 11 bits unsigned. ctr_h=h-1 and ctr_v=v-1 never underflow because of the gating.

Test Plan:
1. HMAX=5, VMAX=4, DW=8, pixel=16*v+h, continuous valid. The first win_valid comes 1 clk after accepting (2,2), with ctr=(1,1) and win_first=1. Taps row0=00,01,02; row1=10,11,12; row2=20,21,22. Exactly 6 windows per frame; the last is ctr=(2,3), taps 13,14,23,24,33,34 in the right columns, with win_last=1.
2. Same stream with random 0-3 cycle gaps on pix_valid. The window sequence and values are identical to scenario 1. win_valid is never asserted in a gap cycle.
3. Two back-to-back frames, with frame 2 pixels = 0x80+16*v+h. Frame 2 emits no window before accepting (2,2); its first window taps are 80,81,82,90,91,92,A0,A1,A2. No frame 1 value appears.
4. Assert reset at pixel (2,3) of frame 1. All outputs are 0 on the same edge. After restart at (0,0), the output matches scenario 1 exactly.
5. Assert sync_clr together with pix_valid at (3,1), then restart at (0,0). There is no win_valid in the cycle after sync_clr, and the new frame output matches scenario 1.
6. Present pix_valid=1 with hcount=5 (>=HMAX) between valid pixels. There is no RAM write and no window shift; subsequent windows are unchanged versus scenario 1.
